pool1_buf_scheduler: RTL
========================

// Module: pool1_buf_scheduler
// PURPOSE
//  Sequences writes into the pool1 output line buffer (ring of MEM_HEIGHT rows) from the pool1 stage.
//  Accepts one 2x2 pixel group per valid/ready handshake and holds it stable while the buffer stores it.
//  Issues the buffer's edge-triggered start pulse with legal spacing.
//  Tracks row-pair occupancy against consumer (conv2) releases, so unread rows are never overwritten.
// PARAMETERS
//  DATA_W      256  width of one pixel group (CH_NUM<<BITS_SHIFT = 16<<4)
//  LENGTH      29   input picture length
//  HEIGHT      29   input picture height
//  STRIDE_IN   2    columns/rows advanced per group
//  PAR_NUM     4    buffer write cycles per group (one quadrant per cycle)
//  MEM_HEIGHT  8    buffer rows; CAP = MEM_HEIGHT/STRIDE_IN = 4 row pairs
//  CNT_W       5    width of column/row-pair counters
// PORTS
//  clk_in      in   1       clock
//  rst         in   1       synchronous reset, active-high
//  frame_start in   1       pulse: arm for a new frame (honoured in IDLE only)
//  up_valid    in   1       upstream group valid
//  up_data     in   DATA_W  upstream group
//  up_ready    out  1       scheduler accepts group this cycle
//  buf_start   out  1       start pulse to line buffer
//  buf_data    out  DATA_W  held group to buffer data_in
//  rel_pair    in   1       consumer finished one row pair (pulse)
//  occ         out  3       row pairs written and not yet released (0..CAP)
//  frame_done  out  1       one-cycle pulse after last group's write completes
//  err_underflow out 1      sticky: rel_pair seen while occ==0
// BEHAVIOUR
//  Reset: state=IDLE; up_ready=0, buf_start=0, buf_data=0, occ=0, frame_done=0, err_underflow=0; counters=0.
//  Derived: GPR = (LENGTH+STRIDE_IN-1)/STRIDE_IN = 15 groups/row pair; NPAIR = 15 row pairs/frame.
//  States: IDLE -> ARMED (frame_start; clears col/pair counters) -> WRITE -> GAP -> ARMED | DONE -> IDLE.
//  up_ready = (state==ARMED) && (col!=0 || occ<CAP); combinational from registered state only, never from up_valid.
//  Handshake at cycle T (up_valid&up_ready):
//   - buf_data<=up_data; buf_start=1 in T+1 only; state WRITE during T+1..T+PAR_NUM+1.
//   - GAP in T+PAR_NUM+2; ARMED from T+PAR_NUM+3. Earliest next handshake is T+7 for PAR_NUM=4.
//   - Spacing guarantees the buffer sees start low in its wait state before the next rising edge.
//  buf_data changes only on handshake; it is stable for the whole write window.
//  Column/pair counting on handshake:
//   - col==GPR-1 -> col=0, pair++; else col++.
//   - Handshake with col==0 reserves a row pair: occ++.
//  rel_pair: occ--. Reserve and release in the same cycle -> occ unchanged.
//   - Release at occ==0 -> occ stays 0, err_underflow=1 (cleared by rst only).
//  Releases are counted in every state, including IDLE/DONE.
//  Stall: at col==0 with occ==CAP, up_ready=0 until a release registers. up_ready=1 the cycle after rel_pair.
//  Last group (pair==NPAIR-1, col==GPR-1): after GAP go DONE; frame_done=1 one cycle; -> IDLE.
//   - occ is NOT cleared; the consumer drains it.
//  frame_start outside IDLE is ignored. up_valid in IDLE/DONE is ignored (up_ready=0).
//  rst mid-WRITE: immediate IDLE, buf_start=0. The buffer is reset alongside by the system.
// STRUCTURE
//  pool1_sched_pkg: state encodings (IDLE, ARMED, WRITE, GAP, DONE), GPR, NPAIR, CAP, write-window length.
//  Sub-module pool1_row_credit: occ up/down counter with saturation and underflow flag.
//  FSM, write-window counter, col/pair counters and data hold register stay in the top.
// TESTING
//  1 Reset: assert rst 3 cycles -> all outputs 0, up_ready=0 even with up_valid=1.
//  2 Single group: frame_start, up_valid with data 0xA5.. at T
//    -> buf_start only at T+1; buf_data=0xA5.. T+1..T+5; up_ready low until T+7.
//  3 Full frame: 225 groups, consumer releases 1 pair per 15 groups
//    -> exactly 225 buf_start pulses, frame_done once, 7 cycles after the last handshake.
//  4 Backpressure: no releases; 4 row pairs (60 groups) written -> up_ready=0 at pair 4 col 0, occ=4.
//    One rel_pair pulse -> up_ready=1 the next cycle.
//  5 Simultaneous: rel_pair in the same cycle as a col==0 handshake at occ=2 -> occ stays 2.
//    rel_pair at occ=0 -> err_underflow=1, occ=0.
//  6 Reset mid-write at T+3 -> next cycle IDLE, buf_start=0, occ=0.
//    New frame then behaves as in test 2.

Source files
------------

// File: rtl/pool1_sched_pkg.sv
// Shared state encoding and geometry helpers for the pool1 line-buffer write scheduler.
package pool1_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  localparam int LENGTH_DEF     = 29;
  localparam int HEIGHT_DEF     = 29;
  localparam int STRIDE_IN_DEF  = 2;
  localparam int PAR_NUM_DEF    = 4;
  localparam int MEM_HEIGHT_DEF = 8;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Groups per row pair, row pairs per frame, ring capacity in pairs, WRITE-state length.
  localparam int GPR   = ceil_div(LENGTH_DEF, STRIDE_IN_DEF);
  localparam int NPAIR = ceil_div(HEIGHT_DEF, STRIDE_IN_DEF);
  localparam int CAP   = MEM_HEIGHT_DEF / STRIDE_IN_DEF;
  localparam int WIN   = PAR_NUM_DEF + 1;

endpackage

// File: rtl/pool1_row_credit.sv
// Row-pair occupancy counter: reserve on the first group of a pair, release on consumer pulse.
module pool1_row_credit #(
  parameter int CAP   = 4,
  parameter int OCC_W = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             reserve_i,
  input  logic             release_i,
  output logic [OCC_W-1:0] occ_o,
  output logic             full_o,
  output logic             err_underflow_o
);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  // A reserve and a release in the same cycle cancel, even at zero occupancy.
  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    if (reserve_i && !release_i) begin
      if (occ_q != OCC_W'(CAP)) occ_d = occ_q + 1'b1;
    end else if (release_i && !reserve_i) begin
      if (occ_q == '0) err_d = 1'b1;
      else             occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign occ_o           = occ_q;
  assign full_o          = (occ_q == OCC_W'(CAP));
  assign err_underflow_o = err_q;

endmodule

// File: rtl/pool1_buf_scheduler.sv
// Sequences pool1 pixel groups into the line buffer with spaced start pulses and row-pair credit.
import pool1_sched_pkg::*;

module pool1_buf_scheduler #(
  parameter int DATA_W     = 256,
  parameter int LENGTH     = LENGTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int STRIDE_IN  = STRIDE_IN_DEF,
  parameter int PAR_NUM    = PAR_NUM_DEF,
  parameter int MEM_HEIGHT = MEM_HEIGHT_DEF,
  parameter int CNT_W      = 5
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              buf_start,
  output logic [DATA_W-1:0] buf_data,
  input  logic              rel_pair,
  output logic [2:0]        occ,
  output logic              frame_done,
  output logic              err_underflow,
  output sched_state_e      dbg_state
);

  localparam int L_GPR   = ceil_div(LENGTH, STRIDE_IN);
  localparam int L_NPAIR = ceil_div(HEIGHT, STRIDE_IN);
  localparam int L_CAP   = MEM_HEIGHT / STRIDE_IN;
  localparam int L_WIN   = PAR_NUM + 1;
  localparam int WCNT_W  = $clog2(L_WIN);

  // Handshake: a group transfers on a cycle where up_valid && up_ready; up_ready never looks at up_valid.
  sched_state_e      state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0]  col_q, pair_q;
  logic              last_q;
  logic              buf_start_q;
  logic [DATA_W-1:0] buf_data_q;
  logic              frame_done_q;
  logic              credit_full;
  logic              hs;

  assign up_ready = (state_q == ST_ARMED) && ((col_q != '0) || !credit_full);
  assign hs       = up_valid && up_ready;

  pool1_row_credit #(.CAP(L_CAP), .OCC_W(3)) u_credit (
    .clk_in          (clk_in),
    .rst             (rst),
    .reserve_i       (hs && (col_q == '0)),
    .release_i       (rel_pair),
    .occ_o           (occ),
    .full_o          (credit_full),
    .err_underflow_o (err_underflow)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      col_q        <= '0;
      pair_q       <= '0;
      last_q       <= 1'b0;
      buf_start_q  <= 1'b0;
      buf_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      buf_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q <= ST_ARMED;
            col_q   <= '0;
            pair_q  <= '0;
          end
        end
        ST_ARMED: begin
          if (hs) begin
            state_q     <= ST_WRITE;
            buf_start_q <= 1'b1;
            buf_data_q  <= up_data;
            wcnt_q      <= '0;
            last_q      <= (pair_q == CNT_W'(L_NPAIR - 1)) && (col_q == CNT_W'(L_GPR - 1));
            if (col_q == CNT_W'(L_GPR - 1)) begin
              col_q  <= '0;
              pair_q <= pair_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        // The extra WRITE cycle plus GAP keeps start low long enough for the buffer to re-arm.
        ST_WRITE: begin
          if (wcnt_q == WCNT_W'(L_WIN - 1)) state_q <= ST_GAP;
          else                              wcnt_q  <= wcnt_q + 1'b1;
        end
        ST_GAP: begin
          if (last_q) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end else begin
            state_q <= ST_ARMED;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign buf_start  = buf_start_q;
  assign buf_data   = buf_data_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule
